// File: rtl/lut_rd_ctrl_if.sv
// Request/response stream bundle for the LUT read controller.
// The slave side is the controller; the master side issues lookups and consumes results.
interface lut_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/lut_rd_ctrl.sv
// Read-side initiator for a fixed-latency LUT ROM: issues addresses, tracks in-flight
// reads and buffers results in a first-word-fall-through FIFO under credit flow control.
module lut_rd_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  lut_rd_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_clk_en_o,
  output logic                  rom_addr_strobe_o,
  output logic                  rom_rd_oce_o,
  input  logic [DATA_WIDTH-1:0] rom_rd_data_i,
  output logic                  busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!(RD_LATENCY == 1 || RD_LATENCY == 2) || (FIFO_DEPTH < RD_LATENCY + 1) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
    $error("lut_rd_ctrl: illegal RD_LATENCY/FIFO_DEPTH combination");
  end

  logic                  ready_en_q;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CNT_W-1:0]      inflight_cnt;
  logic [CNT_W:0]        credit_used;
  logic                  req_ready, rsp_valid, fire, push, pop;

  // Credits cover both reads still in the ROM pipe and buffered results, so every
  // accepted lookup already owns a FIFO slot and the ROM never has to stall.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_q[i]);
    end
    credit_used = {1'b0, inflight_cnt} + {1'b0, cnt_q};
    req_ready   = ready_en_q && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    rsp_valid   = (cnt_q != '0);
    fire        = bus.req_valid && req_ready;
    push        = pipe_q[RD_LATENCY-1];
    pop         = rsp_valid && bus.rsp_ready;
  end

  always_comb begin
    pipe_d   = RD_LATENCY'({pipe_q, fire});
    addr_d   = fire ? bus.req_addr : addr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      pipe_q     <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      ready_en_q <= 1'b1;
      pipe_q     <= pipe_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rom_rd_data_i;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_data      = rsp_valid ? mem_q[rd_ptr_q] : '0;
  assign rom_addr_o        = addr_d;
  assign rom_clk_en_o      = 1'b1;
  assign rom_addr_strobe_o = 1'b0;
  assign rom_rd_oce_o      = 1'b1;
  assign busy_o            = (inflight_cnt != '0) || (cnt_q != '0);

endmodule

// File: tb/tb_lut_rd_ctrl.sv
// Bench for lut_rd_ctrl: one instance per legal read latency, each with a ROM model and a
// queue-based reference of outstanding lookups that predicts every output each cycle.
module tb_lut_rd_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid [2];
  logic [AW-1:0] reqAddr [2];
  logic          rspReady [2];
  int            randMode;
  int            total = 0;
  int            bad = 0;

  logic          rdyW [2], vldW [2], busyW [2];
  logic [DW-1:0] datW [2];
  logic [AW-1:0] raW [2];
  logic [2:0]    tieW [2];
  logic          eRdyW [2], eVldW [2], eBusyW [2];
  logic [DW-1:0] eDatW [2];
  logic [AW-1:0] eRaW [2];
  int            mSizeW [2];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lutVal(input logic [AW-1:0] a);
    return DW'(a) * 3 + 7;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = g + 1;
    lut_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [AW-1:0] romAddr;
    logic [DW-1:0] romData, romStage;
    logic          clkEn, strobe, oce, busy;
    entry_t        pend [$];
    int            mCyc = 0, mSize = 0, mHeadVis = 0;
    bit            mStarted = 1'b0;
    logic [DW-1:0] mHeadData = '0;
    logic [AW-1:0] mLastAddr = '0;

    assign bus.req_valid = reqValid[g];
    assign bus.req_addr  = reqAddr[g];
    assign bus.rsp_ready = rspReady[g];

    lut_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .rom_addr_o(romAddr), .rom_clk_en_o(clkEn), .rom_addr_strobe_o(strobe),
      .rom_rd_oce_o(oce), .rom_rd_data_i(romData), .busy_o(busy)
    );

    // ROM: data[a] = a*3+7 appears LAT edges after the address is sampled.
    always @(posedge clk) begin
      romStage <= lutVal(romAddr);
      romData  <= (LAT == 1) ? lutVal(romAddr) : romStage;
    end

    // Reference: a queue of accepted-but-unconsumed lookups, each visible LAT edges after acceptance.
    always @(posedge clk) begin
      bit mFire, mPop;
      if (rst) begin
        pend.delete();
        mStarted  = 1'b0;
        mLastAddr = '0;
      end else begin
        mFire = reqValid[g] && mStarted && (pend.size() < DEPTH);
        mPop  = rspReady[g] && (pend.size() > 0) && (pend[0].vis <= mCyc);
        if (mPop) void'(pend.pop_front());
        if (mFire) begin
          pend.push_back('{lutVal(reqAddr[g]), mCyc + 1 + LAT});
          mLastAddr = reqAddr[g];
        end
        mStarted = 1'b1;
      end
      mCyc++;
      mSize     = pend.size();
      mHeadVis  = (pend.size() > 0) ? pend[0].vis : 0;
      mHeadData = (pend.size() > 0) ? pend[0].data : '0;
    end

    assign rdyW[g]   = bus.req_ready;
    assign vldW[g]   = bus.rsp_valid;
    assign datW[g]   = bus.rsp_data;
    assign busyW[g]  = busy;
    assign raW[g]    = romAddr;
    assign tieW[g]   = {clkEn, strobe, oce};
    assign eRdyW[g]  = !rst && mStarted && (mSize < DEPTH);
    assign eVldW[g]  = !rst && (mSize > 0) && (mHeadVis <= mCyc);
    assign eDatW[g]  = eVldW[g] ? mHeadData : '0;
    assign eBusyW[g] = !rst && (mSize > 0);
    assign eRaW[g]   = rst ? '0 : ((reqValid[g] && eRdyW[g]) ? reqAddr[g] : mLastAddr);
    assign mSizeW[g] = mSize;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("mon%0d_req_ready", i), DW'(rdyW[i]), DW'(eRdyW[i]));
        checkOutput($sformatf("mon%0d_rsp_valid", i), DW'(vldW[i]), DW'(eVldW[i]));
        checkOutput($sformatf("mon%0d_busy", i), DW'(busyW[i]), DW'(eBusyW[i]));
        checkOutput($sformatf("mon%0d_rom_addr", i), DW'(raW[i]), DW'(eRaW[i]));
        if (eVldW[i] || rst) checkOutput($sformatf("mon%0d_rsp_data", i), datW[i], eDatW[i]);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds one request until it is accepted or the cycle budget runs out.
  task automatic applyStimulus(input int idx, input logic [AW-1:0] a, input int budget,
                               output bit fired, output int waited);
    reqValid[idx] = 1'b1;
    reqAddr[idx]  = a;
    fired  = 1'b0;
    waited = 0;
    forever begin
      @(negedge clk);
      if (rdyW[idx]) begin
        fired = 1'b1;
        break;
      end
      waited++;
      if (waited >= budget) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    reqValid[idx] = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((mSizeW[0] != 0 || mSizeW[1] != 0) && n < budget) begin
      step(1);
      n++;
    end
    checkOutput("drain_pending", DW'(mSizeW[0] + mSizeW[1]), '0);
  endtask

  task automatic waitRsp(input int idx, input logic [DW-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (!vldW[idx] && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("fresh%0d_valid", idx), DW'(vldW[idx]), 1);
    checkOutput($sformatf("fresh%0d_data", idx), datW[idx], exp);
  endtask

  initial begin
    bit fired;
    int waited, stalls, rejected;
    randMode = 0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      reqValid[i] = 1'b0;
      reqAddr[i]  = '0;
      rspReady[i] = 1'b0;
    end
    #1 rst = 1'b1;
    fork
      monitorLoop();
      forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
          if (randMode == 1) rspReady[i] = 1'($urandom_range(0, 1));
          else if (randMode == 2) rspReady[i] = ~rspReady[i];
        end
      end
      begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
      end
    join_none

    // Reset values and ROM tie-offs.
    step(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst%0d_req_ready", i), DW'(rdyW[i]), 0);
      checkOutput($sformatf("rst%0d_rsp_valid", i), DW'(vldW[i]), 0);
      checkOutput($sformatf("rst%0d_rsp_data", i), datW[i], 0);
      checkOutput($sformatf("rst%0d_busy", i), DW'(busyW[i]), 0);
    end
    step(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_before_first_edge", DW'(rdyW[0]), 0);
    step(2);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("tie%0d", i), DW'(tieW[i]), DW'(3'b101));

    $display("[TB] single lookup, latency 1");
    applyStimulus(0, 10'd5, 3, fired, waited);
    checkOutput("single_fired", DW'(fired), 1);
    @(negedge clk);
    checkOutput("single_early_valid", DW'(vldW[0]), 0);
    checkOutput("single_early_busy", DW'(busyW[0]), 1);
    step(1);
    @(negedge clk);
    checkOutput("single_valid", DW'(vldW[0]), 1);
    checkOutput("single_data", datW[0], 32'd22);
    checkOutput("single_busy", DW'(busyW[0]), 1);
    step(1);
    rspReady[0] = 1'b1;
    step(1);
    @(negedge clk);
    checkOutput("single_after_pop_busy", DW'(busyW[0]), 0);

    $display("[TB] streaming, latency 2");
    rspReady[1] = 1'b1;
    stalls = 0;
    for (int a = 0; a < 64; a++) begin
      applyStimulus(1, AW'(a), 3, fired, waited);
      if (!fired || waited != 0) stalls++;
    end
    checkOutput("stream_stalls", DW'(stalls), 0);
    waitIdle(20);

    $display("[TB] backpressure, latency 1");
    rspReady[0] = 1'b0;
    rejected = 0;
    for (int a = 100; a < 104; a++) begin
      applyStimulus(0, AW'(a), 3, fired, waited);
      if (!fired) rejected++;
    end
    checkOutput("bp_accepted_four", DW'(rejected), 0);
    applyStimulus(0, 10'd104, 5, fired, waited);
    checkOutput("bp_fifth_blocked", DW'(fired), 0);
    @(negedge clk);
    checkOutput("bp_head_valid", DW'(vldW[0]), 1);
    checkOutput("bp_head_data", datW[0], 32'd307);
    step(1);
    rspReady[0] = 1'b1;
    applyStimulus(0, 10'd104, 5, fired, waited);
    checkOutput("bp_resume_fired", DW'(fired), 1);
    checkOutput("bp_resume_wait", DW'(waited), 1);
    waitIdle(20);

    $display("[TB] random stall");
    randMode = 1;
    fork
      for (int i = 0; i < 500; i++) begin
        bit f;
        int w;
        applyStimulus(0, AW'($urandom_range(0, 1023)), 100, f, w);
        if (!f) checkOutput("rand0_accept", DW'(f), 1);
        if ($urandom_range(0, 3) == 0) step(1);
      end
      for (int i = 0; i < 500; i++) begin
        bit f;
        int w;
        applyStimulus(1, AW'($urandom_range(0, 1023)), 100, f, w);
        if (!f) checkOutput("rand1_accept", DW'(f), 1);
        if ($urandom_range(0, 3) == 0) step(1);
      end
    join
    randMode = 0;
    rspReady[0] = 1'b1;
    rspReady[1] = 1'b1;
    waitIdle(40);

    $display("[TB] wrap with alternating rsp_ready");
    randMode = 2;
    fork
      for (int i = 0; i < 20; i++) begin
        bit f;
        int w;
        applyStimulus(0, AW'(200 + i), 20, f, w);
        if (!f) checkOutput("wrap0_accept", DW'(f), 1);
      end
      for (int i = 0; i < 20; i++) begin
        bit f;
        int w;
        applyStimulus(1, AW'(300 + i), 20, f, w);
        if (!f) checkOutput("wrap1_accept", DW'(f), 1);
      end
    join
    randMode = 0;
    rspReady[0] = 1'b1;
    rspReady[1] = 1'b1;
    waitIdle(40);

    $display("[TB] reset mid-operation");
    rspReady[0] = 1'b0;
    rspReady[1] = 1'b0;
    fork
      for (int a = 7; a < 10; a++) begin
        bit f;
        int w;
        applyStimulus(0, AW'(a), 5, f, w);
      end
      for (int a = 7; a < 10; a++) begin
        bit f;
        int w;
        applyStimulus(1, AW'(a), 5, f, w);
      end
    join
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("midrst%0d_valid", i), DW'(vldW[i]), 0);
      checkOutput($sformatf("midrst%0d_busy", i), DW'(busyW[i]), 0);
    end
    step(2);
    rst = 1'b0;
    rspReady[0] = 1'b1;
    rspReady[1] = 1'b1;
    step(4);
    @(negedge clk);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("postrst%0d_stale", i), DW'(vldW[i]), 0);
    step(1);
    applyStimulus(0, 10'd1, 5, fired, waited);
    checkOutput("fresh0_fired", DW'(fired), 1);
    waitRsp(0, 32'd10);
    step(1);
    applyStimulus(1, 10'd1, 5, fired, waited);
    checkOutput("fresh1_fired", DW'(fired), 1);
    waitRsp(1, 32'd10);
    step(1);
    waitIdle(20);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lut_rd_ctrl.md
Name: lut_rd_ctrl

Overview:
- Read-side initiator for the G_LUT ROM (ipml_rom-based lookup table).
- Accepts lookup requests on a valid/ready address stream and drives the ROM address port.
- Tracks the ROM's fixed read latency and captures rd_data into a small response FIFO.
- Returns results on a valid/ready data stream; no lookup is lost or reordered under downstream backpressure.

Parameters:
- ADDR_WIDTH, 10, LUT address width; must match the ROM c_ADDR_WIDTH.
- DATA_WIDTH, 32, LUT data width; must match the ROM c_DATA_WIDTH.
- RD_LATENCY, 1, cycles from address sampled to rd_data valid. 1 = ROM c_OUTPUT_REG=0; 2 = c_OUTPUT_REG=1. Legal: 1 or 2.
- FIFO_DEPTH, 4, response FIFO entries. Power of 2; must be >= RD_LATENCY+1.

Ports:
- clk, input, 1: single clock, shared with the ROM.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: lookup request valid.
- req_ready, output, 1: request accepted when req_valid && req_ready.
- req_addr, input, ADDR_WIDTH: LUT index.
- rom_addr, output, ADDR_WIDTH: to ROM addr.
- rom_clk_en, output, 1: to ROM clk_en.
- rom_addr_strobe, output, 1: to ROM addr_strobe.
- rom_rd_oce, output, 1: to ROM rd_oce.
- rom_rd_data, input, DATA_WIDTH: from ROM rd_data.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response consumed when rsp_valid && rsp_ready.
- rsp_data, output, DATA_WIDTH: LUT value, in request order.
- busy, output, 1: high while any lookup is in flight or buffered.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rom_addr=0, busy=0. FIFO pointers, in-flight pipe and counters are cleared. req_ready rises on the first clk edge after rst deasserts.
- ROM tie-offs: rom_clk_en=1, rom_addr_strobe=0, rom_rd_oce=1, constant outside reset.
- Issue: rom_addr is combinationally req_addr when a request fires. When no request fires, rom_addr holds the last issued address (registered copy). The ROM samples it at the same edge as the handshake.
- In-flight pipe: a RD_LATENCY-deep shift register of valid bits. Bit 0 is set on a handshake. When the last stage is 1, rom_rd_data is written into the FIFO on that edge.
- Credit rule: req_ready = (inflight_cnt + fifo_cnt) < FIFO_DEPTH. inflight_cnt is the population of the pipe (0..RD_LATENCY). This guarantees the FIFO can never overflow, and the ROM is never stalled.
- Throughput: 1 lookup/cycle sustained while rsp_ready=1.
- Latency: request handshake at edge N puts data in the FIFO at edge N+RD_LATENCY. rsp_valid is high in the cycle after that edge (FWFT output). Total: RD_LATENCY+1 cycles from request to response.
- FIFO: first-word-fall-through. rsp_data = head entry; rsp_valid = fifo_cnt != 0.
- Simultaneous push and pop: fifo_cnt unchanged, and the head advances correctly. A push into an empty FIFO with rsp_ready=1 is still registered first; there is no combinational bypass.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. fifo_cnt is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- busy = (inflight_cnt != 0) || (fifo_cnt != 0).
- Backpressure: with rsp_ready=0, exactly FIFO_DEPTH requests are accepted, then req_ready=0. req_ready reasserts in the cycle after the first pop.
- Reset mid-operation: all in-flight and buffered lookups are discarded. rsp_valid drops immediately (async). No response is produced for pre-reset requests.
- Illegal parameters (RD_LATENCY not 1 or 2, or FIFO_DEPTH < RD_LATENCY+1) are rejected by an elaboration-time check.

Test Plan:
- Single lookup: ROM model holds data[a]=a*3+7, RD_LATENCY=1. req_addr=5 at edge 10 -> rsp_valid at cycle 11 with rsp_data=22. busy is high for cycles 10-11.
- Streaming: addresses 0..63 back-to-back with rsp_ready=1, RD_LATENCY=2 -> req_ready stays 1 throughout. Responses are 7,10,...,196 in order, with no gaps after a first-response latency of 3.
- Backpressure: rsp_ready=0, continuous requests 100..109, FIFO_DEPTH=4 -> exactly 4 accepted (100..103), then req_ready=0. Releasing rsp_ready yields 307,310,313,316 and accepts 104 next.
- Random stall: 1000 random addresses with 50% random rsp_ready -> every response equals data[addr] in request order. fifo_cnt never exceeds 4, and no push occurs while full.
- Wrap and simultaneous push/pop: rsp_ready toggling 1/0 each cycle for 20 requests -> pointers wrap at least 4 times with no lost or duplicated entries.
- Mid-operation reset: 3 lookups in flight, rst pulsed for 2 cycles -> rsp_valid=0 and busy=0 during reset. No stale response afterwards; a fresh request to addr 1 returns 10.
